// File: rtl/quadratic_arbiter.sv
// Round-robin front end that time-shares one combinational quadratic evaluator
// among NREQ clients, returning each result over a valid/ready response channel.

module quadratic_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [10*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [9:0]           q_in,
  input  logic [9:0]           q_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [9:0]           rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          done_count
);

  localparam logic [1:0]     IDLE      = 2'd0;
  localparam logic [1:0]     EVAL      = 2'd1;
  localparam logic [1:0]     RESP      = 2'd2;
  localparam logic [3:0]     SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  logic [1:0]      state_r;
  logic [3:0]      cnt_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [9:0]      q_in_r;
  logic            rsp_valid_r;
  logic [9:0]      rsp_data_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [15:0]     done_count_r;

  logic            win_found_s;
  logic [IDW-1:0]  win_id_s;
  logic [IDW:0]    cand_s;
  logic [9:0]      win_data_s;
  logic [NREQ-1:0] req_ready_s;
  logic            accept_s;
  logic [IDW-1:0]  next_ptr_s;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(j);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req_valid[cand_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[IDW-1:0];
      end else begin
        win_id_s    = win_id_s;
      end
    end
  end

  // Operand of the current winner.
  always_comb begin
    win_data_s = 10'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id_s == IDW'(i)) begin
        win_data_s = req_data[10*i +: 10];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Grant is offered only while idle and out of reset.
  always_comb begin
    req_ready_s = '0;
    accept_s    = 1'b0;
    if (!reset && (state_r == IDLE) && win_found_s) begin
      req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
      accept_s    = 1'b1;
    end else begin
      req_ready_s = '0;
      accept_s    = 1'b0;
    end
  end

  // The finishing requester drops to lowest priority next time round.
  always_comb begin
    next_ptr_s = '0;
    if (rsp_id_r == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = rsp_id_r + IDW'(1);
    end
  end

  // Transaction sequencer: accept, hold operand for SETTLE cycles, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      rr_ptr_r     <= '0;
      q_in_r       <= 10'd0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 10'd0;
      rsp_id_r     <= '0;
      done_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            q_in_r   <= win_data_s;
            rsp_id_r <= win_id_s;
            cnt_r    <= SETTLE_M1;
            state_r  <= EVAL;
          end else begin
            state_r  <= IDLE;
          end
        end
        EVAL: begin
          if (cnt_r != 4'd0) begin
            cnt_r       <= cnt_r - 4'd1;
          end else begin
            rsp_data_r  <= q_out;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            done_count_r <= done_count_r + 16'd1;
            rr_ptr_r     <= next_ptr_s;
            state_r      <= IDLE;
          end else begin
            state_r      <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign q_in       = q_in_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_id     = rsp_id_r;
  assign busy       = (state_r != IDLE);
  assign done_count = done_count_r;

  quadratic_arbiter_chk #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_ready (req_ready_s),
    .q_in      (q_in_r),
    .rsp_valid (rsp_valid_r),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data_r),
    .rsp_id    (rsp_id_r),
    .busy      (busy)
  );

endmodule

// Protocol properties of the arbiter: one-hot grant, no grant while busy,
// stable operand during evaluation and stable response under backpressure.
module quadratic_arbiter_chk #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            reset,
  input logic [NREQ-1:0] req_ready,
  input logic [9:0]      q_in,
  input logic            rsp_valid,
  input logic            rsp_ready,
  input logic [9:0]      rsp_data,
  input logic [IDW-1:0]  rsp_id,
  input logic            busy
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_no_grant_busy: assert property (@(posedge clk) disable iff (reset)
    busy |-> (req_ready == '0));

  a_operand_hold: assert property (@(posedge clk) disable iff (reset)
    (busy && !rsp_valid) |=> $stable(q_in));

  a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_quadratic_arbiter.sv
// Directed bench for quadratic_arbiter: a SETTLE=1 instance for most scenarios
// and a SETTLE=3 instance for settle timing; the evaluator is modelled here.

module tb_quadratic_arbiter;

  logic        clk;
  logic        reset;

  logic [3:0]  req_valid;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic [9:0]  q_in;
  logic [9:0]  q_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [9:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] done_count;

  logic [3:0]  s3_req_valid;
  logic [39:0] s3_req_data;
  logic [3:0]  s3_req_ready;
  logic [9:0]  s3_q_in;
  logic [9:0]  s3_q_out;
  logic        s3_rsp_valid;
  logic        s3_rsp_ready;
  logic [9:0]  s3_rsp_data;
  logic [1:0]  s3_rsp_id;
  logic        s3_busy;
  logic [15:0] s3_done_count;

  int total = 0;
  int bad   = 0;

  logic [9:0] rr_data [4];

  // Reference evaluator: y = x*x in Q5.5, truncated to 10 bits.
  function automatic logic [9:0] quad_model(input logic [9:0] x);
    logic signed [19:0] xs;
    logic signed [19:0] p;
    xs = {{10{x[9]}}, x};
    p  = xs * xs;
    return p[14:5];
  endfunction

  assign q_out    = quad_model(q_in);
  assign s3_q_out = quad_model(s3_q_in);

  quadratic_arbiter #(.NREQ(4), .IDW(2), .SETTLE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .q_in       (q_in),
    .q_out      (q_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .done_count (done_count)
  );

  quadratic_arbiter #(.NREQ(4), .IDW(2), .SETTLE(3)) dut_s3 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (s3_req_valid),
    .req_data   (s3_req_data),
    .req_ready  (s3_req_ready),
    .q_in       (s3_q_in),
    .q_out      (s3_q_out),
    .rsp_valid  (s3_rsp_valid),
    .rsp_ready  (s3_rsp_ready),
    .rsp_data   (s3_rsp_data),
    .rsp_id     (s3_rsp_id),
    .busy       (s3_busy),
    .done_count (s3_done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 4'b1111; req_data = 40'd0; rsp_ready = 1'b0;
    s3_req_valid = 4'b1111; s3_req_data = 40'd0; s3_rsp_ready = 1'b0;
    tick; tick;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if (s3_req_ready !== 4'b0000) begin bad++; $display("FAIL reset_s3_req_ready: got %b want 0000", s3_req_ready); end
    total++; if (q_in !== 10'h000 || rsp_data !== 10'h000 || rsp_id !== 2'd0) begin
      bad++; $display("FAIL reset_regs: got q_in=%h rsp_data=%h rsp_id=%0d want 0/0/0", q_in, rsp_data, rsp_id); end
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
      bad++; $display("FAIL reset_ctrl: got rsp_valid=%b busy=%b done=%0d want 0/0/0", rsp_valid, busy, done_count); end
    req_valid = 4'b0000; s3_req_valid = 4'b0000; reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    req_valid = 4'b0001; req_data[9:0] = 10'h020; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick;
    req_valid = 4'b0000;
    total++; if (q_in !== 10'h020 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_accept: got q_in=%h busy=%b rsp_valid=%b want 020/1/0", q_in, busy, rsp_valid); end
    tick;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== quad_model(10'h020) || rsp_id !== 2'd0) begin
      bad++; $display("FAIL single_rsp: got v=%b d=%h id=%0d want 1/%h/0", rsp_valid, rsp_data, rsp_id, quad_model(10'h020)); end
    tick;
    total++; if (rsp_valid !== 1'b0 || done_count !== 16'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_done: got v=%b done=%0d busy=%b want 0/1/0", rsp_valid, done_count, busy); end
  endtask

  task automatic test_round_robin;
    int exp_ids [5];
    logic [3:0] exp_oh;
    int k;
    exp_ids = '{0, 1, 2, 3, 0};
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 4; i++) req_data[10*i +: 10] = rr_data[i];
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      k = 0;
      while (req_ready == 4'b0000 && k < 10) begin tick; k++; end
      exp_oh = 4'b0001 << exp_ids[n];
      total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, exp_oh); end
      tick;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 10) begin tick; k++; end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_ids[n]) || rsp_data !== quad_model(rr_data[exp_ids[n]])) begin
        bad++; $display("FAIL rr_rsp%0d: got v=%b id=%0d d=%h want 1/%0d/%h", n, rsp_valid, rsp_id, rsp_data,
                        exp_ids[n], quad_model(rr_data[exp_ids[n]])); end
      tick;
    end
    req_valid = 4'b0000;
    total++; if (done_count !== 16'd5) begin bad++; $display("FAIL rr_done: got %0d want 5", done_count); end
  endtask

  task automatic test_backpressure;
    int k;
    rsp_ready = 1'b0;
    req_valid = 4'b1000; req_data[39:30] = 10'h040; req_data[9:0] = 10'h020;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    tick;
    req_valid = 4'b0001;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 10) begin tick; k++; end
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_data !== quad_model(10'h040) || rsp_id !== 2'd3 ||
                   req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b busy=%b want 1/%h/3/0000/1",
                        c, rsp_valid, rsp_data, rsp_id, req_ready, busy, quad_model(10'h040)); end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd6) begin
      bad++; $display("FAIL bp_release: got v=%b busy=%b done=%0d want 0/0/6", rsp_valid, busy, done_count); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    tick;
    total++; if (busy !== 1'b0 || q_in !== 10'h040 || done_count !== 16'd6) begin
      bad++; $display("FAIL drop_no_effect: got busy=%b q_in=%h done=%0d want 0/040/6", busy, q_in, done_count); end
  endtask

  task automatic test_settle;
    s3_rsp_ready = 1'b1;
    s3_req_valid = 4'b0100; s3_req_data[29:20] = 10'h060;
    #1;
    total++; if (s3_req_ready !== 4'b0100) begin bad++; $display("FAIL settle_grant: got %b want 0100", s3_req_ready); end
    tick;
    s3_req_valid = 4'b0000;
    total++; if (s3_q_in !== 10'h060 || s3_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL settle_t0: got q_in=%h v=%b want 060/0", s3_q_in, s3_rsp_valid); end
    for (int e = 1; e <= 3; e++) begin
      tick;
      total++; if (s3_q_in !== 10'h060 || s3_rsp_valid !== (e == 3)) begin
        bad++; $display("FAIL settle_t%0d: got q_in=%h v=%b want 060/%0d", e, s3_q_in, s3_rsp_valid, (e == 3)); end
    end
    total++; if (s3_rsp_data !== quad_model(10'h060) || s3_rsp_id !== 2'd2) begin
      bad++; $display("FAIL settle_rsp: got d=%h id=%0d want %h/2", s3_rsp_data, s3_rsp_id, quad_model(10'h060)); end
    tick;
    total++; if (s3_done_count !== 16'd1 || s3_busy !== 1'b0) begin
      bad++; $display("FAIL settle_done: got done=%0d busy=%b want 1/0", s3_done_count, s3_busy); end
  endtask

  task automatic test_reset_mid;
    int k;
    rsp_ready = 1'b1;
    req_valid = 4'b0100; req_data[29:20] = 10'h3F8;
    #1; tick;
    req_valid = 4'b0000;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 10) begin tick; k++; end
    tick;
    req_valid = 4'b0010; req_data[19:10] = 10'h030;
    #1; tick;
    reset = 1'b1; req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    tick;
    reset = 1'b0; req_valid = 4'b0000;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0 || q_in !== 10'h000) begin
      bad++; $display("FAIL midrst_state: got v=%b busy=%b done=%0d q_in=%h want 0/0/0/000", rsp_valid, busy, done_count, q_in); end
    tick;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid); end
    req_valid = 4'b1100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL midrst_grant: got %b want 0100", req_ready); end
    tick;
    req_valid = 4'b0000;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 10) begin tick; k++; end
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      bad++; $display("FAIL midrst_rsp: got v=%b id=%0d want 1/2", rsp_valid, rsp_id); end
    tick;
  endtask

  task automatic test_sweep;
    logic [9:0] x;
    int k;
    reset = 1'b1; tick; reset = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 128; n++) begin
      x = 10'(n * 8);
      req_valid = 4'b0010; req_data[19:10] = x;
      #1;
      k = 0;
      while (req_ready[1] !== 1'b1 && k < 10) begin tick; k++; end
      tick;
      req_valid = 4'b0000;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 10) begin tick; k++; end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== quad_model(x)) begin
        bad++; $display("FAIL sweep_%h: got v=%b id=%0d d=%h want 1/1/%h", x, rsp_valid, rsp_id, rsp_data, quad_model(x)); end
      tick;
    end
    total++; if (done_count !== 16'd128) begin bad++; $display("FAIL sweep_done: got %0d want 128", done_count); end
  endtask

  initial begin
    rr_data = '{10'h008, 10'h010, 10'h3F8, 10'h200};
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_settle;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/quadratic_arbiter.md
Name: quadratic_arbiter

Overview:
- Shares one combinational `quadratic` evaluator among NREQ requesters.
- Data format: 10-bit signed Q5.5, value = raw/32.
- Sequences one evaluation at a time: round-robin grant, drive evaluator input, wait a settle interval, capture result, return it with a valid/ready response handshake.
- Sits between client blocks and the single `quadratic` instance; the evaluator connects through the `q_in` and `q_out` ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.
- SETTLE, 1, cycles `q_in` is held before `q_out` is sampled (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  10*NREQ  signed Q5.5 operand; slice i is [10*i+9:10*i].
- req_ready  out  NREQ  one-hot accept; a request transfers when req_valid[i] & req_ready[i].
- q_in  out  10  registered operand to the `quadratic` instance.
- q_out  in  10  signed result from the `quadratic` instance.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  10  signed Q5.5 result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high in EVAL or RESP.
- done_count  out  16  completed transactions; wraps 16'hFFFF -> 0.

Behaviour:
- The clock and reset ports are named clk and reset, as elsewhere in the codebase. There is one clock. reset is synchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - q_in = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, done_count = 0.
  - req_ready = 0 in every cycle where reset is high.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready = one-hot(winner) combinationally; all zero when no request is valid.
  - On transfer: q_in <= req_data[winner]; rsp_id <= winner; cnt <= SETTLE-1; go to EVAL.
- EVAL:
  - req_ready = 0.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: rsp_data <= q_out; rsp_valid <= 1; go to RESP.
  - q_in is held constant throughout.
- RESP:
  - req_ready = 0.
  - rsp_data, rsp_id and rsp_valid are held stable while rsp_ready = 0.
  - When rsp_ready = 1: rsp_valid <= 0; done_count <= done_count + 1; rr_ptr <= (rsp_id + 1) mod NREQ; go to IDLE.
- Latency and throughput:
  - Accept edge to first rsp_valid-high cycle = SETTLE cycles.
  - Minimum spacing between accepts = SETTLE + 2 cycles, assuming rsp_ready is held high.
- busy = (state != IDLE).
- Arithmetic: none. Results pass through unmodified at 10 bits signed; there is no saturation or rounding. The result is whatever the evaluator produces for q_in.
- Boundary conditions:
  - req_valid may drop before it is granted; no transfer occurs and there are no side effects.
  - Requesters keep req_data stable while req_valid is high.
  - Simultaneous requests: exactly one is granted. Fairness: after requester k completes, k has lowest priority in the next arbitration.
  - An ungranted requester waits at most NREQ-1 transactions.
  - rsp_ready may be high before rsp_valid; it has effect only in RESP.
  - Reset mid-EVAL or mid-RESP: the transaction is dropped, no response is produced, rr_ptr returns to 0.
  - done_count wraps silently.

Test Plan:
- Single request: reset 2 cycles; req_valid = 4'b0001, req_data[0] = 10'h020 (1.0); rsp_ready held 1.
  - req_ready = 4'b0001 in the first IDLE cycle.
  - q_in = 10'h020 one edge later.
  - rsp_valid rises SETTLE cycles after the accept edge, with rsp_data == q_out observed at that point and rsp_id = 0.
  - done_count = 1.
- Round-robin: all four requesters valid with data 10'h008, 10'h010, 10'h3F8, 10'h200 (-16.0); rsp_ready = 1.
  - Grant and rsp_id order 0, 1, 2, 3, then 0 again.
  - No requester is skipped or repeated.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid rises.
  - rsp_data and rsp_id are stable, req_ready = 0, busy = 1.
  - Raising rsp_ready completes the transaction in that cycle, then IDLE follows.
- Settle timing: SETTLE = 3, single request at edge t.
  - rsp_valid is first high in the cycle after edge t+3.
  - q_in is constant over edges t+1 .. t+3.
- Reset mid-transaction: assert reset during EVAL.
  - Next cycle: rsp_valid = 0, busy = 0, done_count = 0, q_in = 0.
  - A later request from requester 2 is granted first.
- Sweep: requester 1 issues in = 10'h000 .. 10'h3F8 in steps of 8 (128 requests).
  - done_count = 128.
  - Each rsp_data equals the `quadratic` model output for the corresponding in.
